// File: rtl/dwt_mac_scheduler.sv
// Shares one fixed-latency 8-tap MAC engine between the levels of a wavelet decomposition:
// tracks warm-up and 2:1 phase per level, then arbitrates requests to the engine at a fixed priority.
module dwt_mac_scheduler #(
  parameter int NUM_LEVELS     = 3,
  parameter int WARMUP_SAMPLES = 7,
  parameter int ENGINE_LAT     = 3,
  localparam int SEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_LEVELS-1:0] din_valid,
  input  logic                  clr_ovf,
  output logic [NUM_LEVELS-1:0] hist_shift,
  output logic                  eng_start,
  output logic [SEL_W-1:0]      eng_sel,
  output logic [NUM_LEVELS-1:0] dout_valid,
  output logic                  busy,
  output logic [NUM_LEVELS-1:0] overflow
);

  localparam int WCNT_W = $clog2(WARMUP_SAMPLES + 1);
  localparam logic [WCNT_W-1:0] WARM_MAX = WCNT_W'(WARMUP_SAMPLES);

  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (v == WARM_MAX) ? v : v + WCNT_W'(1);
  endfunction

  logic [NUM_LEVELS-1:0] acc;
  logic [NUM_LEVELS-1:0] warm;
  logic [NUM_LEVELS-1:0] new_req;
  logic [NUM_LEVELS-1:0] req_all;
  logic [NUM_LEVELS-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [NUM_LEVELS-1:0] pending;
  logic [NUM_LEVELS-1:0] pending_next;
  logic [NUM_LEVELS-1:0] ph;
  logic [NUM_LEVELS-1:0] ovf_set;
  logic [NUM_LEVELS-1:0] overflow_next;
  logic [WCNT_W-1:0]     wcnt [NUM_LEVELS];
  logic                  start_next;
  logic [SEL_W-1:0]      sel_next;
  logic                  busy_next;
  logic [NUM_LEVELS-1:0] dout_next;

  // Stage 0 of the in-flight pipe is the launch register itself (eng_start/eng_sel).
  logic [ENGINE_LAT-1:0] vld_p;
  logic [SEL_W-1:0]      sel_p [ENGINE_LAT];

  assign acc        = din_valid & {NUM_LEVELS{en}};
  assign hist_shift = acc;
  assign eng_start  = vld_p[0];
  assign eng_sel    = sel_p[0];

  always_comb begin
    warm      = '0;
    new_req   = '0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      warm[i]    = (wcnt[i] == WARM_MAX);
      new_req[i] = acc[i] & warm[i] & ~ph[i];
    end
    req_all = pending | new_req;
    // Descending scan so the lowest requesting index is the one left standing.
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (req_all[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    pending_next  = (pending & new_req) | (req_all & ~grant);
    ovf_set       = pending & new_req & ~grant;
    overflow_next = ovf_set | (clr_ovf ? '0 : overflow);
    start_next    = |req_all;
    sel_next      = start_next ? grant_idx : sel_p[0];
    busy_next     = (|pending_next) | start_next | (|vld_p);
    dout_next     = vld_p[ENGINE_LAT-1] ? (NUM_LEVELS'(1) << sel_p[ENGINE_LAT-1]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      ph         <= '0;
      overflow   <= '0;
      busy       <= 1'b0;
      dout_valid <= '0;
      vld_p      <= '0;
      for (int j = 0; j < ENGINE_LAT; j++) sel_p[j] <= '0;
      for (int i = 0; i < NUM_LEVELS; i++) wcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (acc[i]) wcnt[i] <= sat_inc(wcnt[i]);
        if (acc[i] && warm[i]) ph[i] <= ~ph[i];
      end
      pending    <= pending_next;
      overflow   <= overflow_next;
      busy       <= busy_next;
      // Launch stage
      vld_p[0]   <= start_next;
      sel_p[0]   <= sel_next;
      // Engine latency stages; the final stage retires into dout_valid
      for (int j = 1; j < ENGINE_LAT; j++) begin
        vld_p[j] <= vld_p[j-1];
        sel_p[j] <= sel_p[j-1];
      end
      dout_valid <= dout_next;
    end
  end

endmodule

// File: tb/tb_dwt_mac_scheduler.sv
// Bench for dwt_mac_scheduler: directed scenarios plus randomized traffic against a
// request-counting reference model of the shared engine.
module tb_dwt_mac_scheduler;
  localparam int L   = 3;
  localparam int W   = 7;
  localparam int LAT = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [L-1:0] din_valid;
  logic         clr_ovf;
  logic [L-1:0] hist_shift;
  logic         eng_start;
  logic [1:0]   eng_sel;
  logic [L-1:0] dout_valid;
  logic         busy;
  logic [L-1:0] overflow;

  dwt_mac_scheduler #(
    .NUM_LEVELS(L),
    .WARMUP_SAMPLES(W),
    .ENGINE_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .din_valid(din_valid),
    .clr_ovf(clr_ovf),
    .hist_shift(hist_shift),
    .eng_start(eng_start),
    .eng_sel(eng_sel),
    .dout_valid(dout_valid),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: sample counts, outstanding requests per level (capacity one),
  // and a short history of engine launches.
  int           nsamp [L];
  int           outstanding [L];
  logic [L-1:0] m_ovf;
  logic         m_start;
  int           m_sel;
  logic         st_q [$];
  int           sel_q [$];
  logic [L-1:0] e_dv;
  logic         e_busy;

  function automatic bit asks_next(input int i);
    return (nsamp[i] >= W) && (((nsamp[i] - W) % 2) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      nsamp[i]       = 0;
      outstanding[i] = 0;
    end
    m_ovf   = '0;
    m_start = 1'b0;
    m_sel   = 0;
    st_q.delete();
    sel_q.delete();
    for (int k = 0; k <= LAT; k++) begin
      st_q.push_front(1'b0);
      sel_q.push_front(0);
    end
    e_dv   = '0;
    e_busy = 1'b0;
  endtask

  task automatic model_clock(input logic [L-1:0] d, input logic e, input logic c);
    int           gi;
    logic [L-1:0] lost;
    gi   = -1;
    lost = '0;
    for (int i = 0; i < L; i++) begin
      if (d[i] && e) begin
        if (asks_next(i)) outstanding[i]++;
        nsamp[i]++;
      end
    end
    for (int i = 0; i < L; i++) if (outstanding[i] > 0 && gi < 0) gi = i;
    if (gi >= 0) outstanding[gi]--;
    for (int i = 0; i < L; i++) begin
      if (outstanding[i] > 1) begin
        lost[i]        = 1'b1;
        outstanding[i] = 1;
      end
    end
    m_ovf   = lost | (c ? '0 : m_ovf);
    m_start = (gi >= 0);
    if (gi >= 0) m_sel = gi;
    st_q.push_front(m_start);
    sel_q.push_front(m_sel);
    while (st_q.size() > LAT + 1) begin
      void'(st_q.pop_back());
      void'(sel_q.pop_back());
    end
    e_dv   = st_q[LAT] ? (L'(1) << sel_q[LAT]) : '0;
    e_busy = 1'b0;
    for (int i = 0; i < L; i++) if (outstanding[i] > 0) e_busy = 1'b1;
    for (int k = 0; k <= LAT; k++) if (st_q[k]) e_busy = 1'b1;
  endtask

  // Drive one cycle of inputs, clock it into DUT and model, land on the next falling edge.
  task automatic step(input logic [L-1:0] d, input logic e, input logic c);
    din_valid = d;
    en        = e;
    clr_ovf   = c;
    @(posedge clk);
    model_clock(d, e, c);
    @(negedge clk);
  endtask

  task automatic align(input int i, input bit want_ph0);
    for (int n = 0; n < 20; n++) begin
      if (nsamp[i] >= W && ((((nsamp[i] - W) % 2) == 0) == want_ph0)) break;
      step(L'(1) << i, 1'b1, 1'b0);
    end
  endtask

  task automatic drain();
    repeat (LAT + 3) step('0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    din_valid = '0;
    clr_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({eng_start, eng_sel, dout_valid, busy, overflow} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got start=%b sel=%0d dv=%b busy=%b ovf=%b, want all 0",
               eng_start, eng_sel, dout_valid, busy, overflow);
    end
    din_valid = 3'b101;
    en        = 1'b1;
    #1;
    compared++;
    if (hist_shift !== 3'b101) begin
      mismatched++;
      $display("FAIL reset_hist_shift_en: got %b want 101", hist_shift);
    end
    en = 1'b0;
    #1;
    compared++;
    if (hist_shift !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_hist_shift_dis: got %b want 000", hist_shift);
    end
    din_valid = '0;
    en        = 1'b1;
    rst_n     = 1'b1;
    model_reset();
  endtask

  task automatic test_warmup();
    logic exp;
    for (int p = 1; p <= 10; p++) begin
      step(3'b001, 1'b1, 1'b0);
      exp = (p == 8 || p == 10);
      compared++;
      if (eng_start !== exp) begin
        mismatched++;
        $display("FAIL warmup_start_p%0d: got %b want %b", p, eng_start, exp);
      end
      if (exp) begin
        compared++;
        if (eng_sel !== 2'd0) begin
          mismatched++;
          $display("FAIL warmup_sel_p%0d: got %0d want 0", p, eng_sel);
        end
      end
      step(3'b000, 1'b1, 1'b0);
    end
    drain();
  endtask

  task automatic test_latency();
    align(0, 1'b1);
    drain();
    for (int k = 1; k <= 5; k++) begin
      step((k == 1) ? 3'b001 : 3'b000, 1'b1, 1'b0);
      compared++;
      if (eng_start !== (k == 1)) begin
        mismatched++;
        $display("FAIL lat_start_t%0d: got %b want %b", k, eng_start, (k == 1));
      end
      if (k == 1) begin
        compared++;
        if (eng_sel !== 2'd0) begin
          mismatched++;
          $display("FAIL lat_sel: got %0d want 0", eng_sel);
        end
      end
      compared++;
      if (dout_valid !== ((k == 4) ? 3'b001 : 3'b000)) begin
        mismatched++;
        $display("FAIL lat_dout_t%0d: got %b want %b", k, dout_valid, (k == 4) ? 3'b001 : 3'b000);
      end
      compared++;
      if (busy !== (k <= 4)) begin
        mismatched++;
        $display("FAIL lat_busy_t%0d: got %b want %b", k, busy, (k <= 4));
      end
    end
  endtask

  task automatic test_contention();
    align(1, 1'b1);
    align(2, 1'b1);
    align(0, 1'b1);
    drain();
    for (int k = 1; k <= 6; k++) begin
      step((k == 1) ? 3'b111 : 3'b000, 1'b1, 1'b0);
      compared++;
      if (eng_start !== (k <= 3)) begin
        mismatched++;
        $display("FAIL cont_start_t%0d: got %b want %b", k, eng_start, (k <= 3));
      end
      if (k <= 3) begin
        compared++;
        if (eng_sel !== 2'(k - 1)) begin
          mismatched++;
          $display("FAIL cont_sel_t%0d: got %0d want %0d", k, eng_sel, k - 1);
        end
      end
      compared++;
      if (dout_valid !== ((k >= 4) ? (L'(1) << (k - 4)) : L'(0))) begin
        mismatched++;
        $display("FAIL cont_dout_t%0d: got %b want %b", k, dout_valid,
                 (k >= 4) ? (L'(1) << (k - 4)) : L'(0));
      end
      compared++;
      if (overflow !== 3'b000) begin
        mismatched++;
        $display("FAIL cont_ovf_t%0d: got %b want 000", k, overflow);
      end
    end
  endtask

  task automatic test_overflow();
    align(0, 1'b1);
    align(1, 1'b0);
    align(2, 1'b1);
    drain();
    step(3'b111, 1'b1, 1'b0);
    compared++;
    if (eng_sel !== 2'd0 || overflow !== 3'b000) begin
      mismatched++;
      $display("FAIL ovf_c1: got sel=%0d ovf=%b want sel=0 ovf=000", eng_sel, overflow);
    end
    step(3'b111, 1'b1, 1'b0);
    compared++;
    if (eng_sel !== 2'd1 || overflow !== 3'b000) begin
      mismatched++;
      $display("FAIL ovf_c2: got sel=%0d ovf=%b want sel=1 ovf=000", eng_sel, overflow);
    end
    step(3'b111, 1'b1, 1'b1);
    compared++;
    if (overflow !== 3'b100) begin
      mismatched++;
      $display("FAIL ovf_set_wins: got %b want 100", overflow);
    end
    step(3'b000, 1'b1, 1'b0);
    compared++;
    if (overflow !== 3'b100 || eng_start !== 1'b1 || eng_sel !== 2'd2) begin
      mismatched++;
      $display("FAIL ovf_sticky: got ovf=%b start=%b sel=%0d want ovf=100 start=1 sel=2",
               overflow, eng_start, eng_sel);
    end
    step(3'b000, 1'b1, 1'b1);
    compared++;
    if (overflow !== 3'b000) begin
      mismatched++;
      $display("FAIL ovf_clear: got %b want 000", overflow);
    end
    drain();
  endtask

  task automatic test_enable();
    align(0, 1'b1);
    drain();
    for (int n = 0; n < 3; n++) begin
      din_valid = 3'b001;
      en        = 1'b0;
      #1;
      compared++;
      if (hist_shift !== 3'b000) begin
        mismatched++;
        $display("FAIL en_hist_shift_%0d: got %b want 000", n, hist_shift);
      end
      step(3'b001, 1'b0, 1'b0);
      compared++;
      if (eng_start !== 1'b0) begin
        mismatched++;
        $display("FAIL en_ignored_%0d: got start=%b want 0", n, eng_start);
      end
    end
    step(3'b001, 1'b1, 1'b0);
    compared++;
    if (eng_start !== 1'b1 || eng_sel !== 2'd0) begin
      mismatched++;
      $display("FAIL en_state_kept: got start=%b sel=%0d want start=1 sel=0", eng_start, eng_sel);
    end
    for (int k = 2; k <= 4; k++) begin
      step(3'b111, 1'b0, 1'b0);
      compared++;
      if (dout_valid !== ((k == 4) ? 3'b001 : 3'b000)) begin
        mismatched++;
        $display("FAIL en_service_t%0d: got %b want %b", k, dout_valid, (k == 4) ? 3'b001 : 3'b000);
      end
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    align(0, 1'b1);
    drain();
    step(3'b001, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({eng_start, eng_sel, dout_valid, busy, overflow} !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got start=%b sel=%0d dv=%b busy=%b ovf=%b, want all 0",
               eng_start, eng_sel, dout_valid, busy, overflow);
    end
    din_valid = 3'b010;
    en        = 1'b1;
    #1;
    compared++;
    if (hist_shift !== 3'b010) begin
      mismatched++;
      $display("FAIL rst_mid_hist_shift: got %b want 010", hist_shift);
    end
    din_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if (dout_valid !== 3'b000 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL rst_mid_hold_%0d: got dv=%b busy=%b want 000/0", k, dout_valid, busy);
      end
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step(3'b000, 1'b1, 1'b0);
      compared++;
      if (dout_valid !== 3'b000 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL rst_mid_after_%0d: got dv=%b busy=%b want 000/0", k, dout_valid, busy);
      end
    end
    for (int p = 1; p <= 8; p++) begin
      step(3'b001, 1'b1, 1'b0);
      compared++;
      if (eng_start !== (p == 8)) begin
        mismatched++;
        $display("FAIL rst_rewarm_p%0d: got %b want %b", p, eng_start, (p == 8));
      end
      step(3'b000, 1'b1, 1'b0);
    end
    drain();
  endtask

  task automatic test_random();
    logic [L-1:0] d;
    logic         e;
    logic         c;
    for (int n = 0; n < 1500; n++) begin
      d[0] = ($urandom_range(0, 99) < 60);
      d[1] = ($urandom_range(0, 99) < 35);
      d[2] = ($urandom_range(0, 99) < 25);
      e    = ($urandom_range(0, 99) < 90);
      c    = ($urandom_range(0, 99) < 5);
      din_valid = d;
      en        = e;
      #1;
      compared++;
      if (hist_shift !== (d & {L{e}})) begin
        mismatched++;
        $display("FAIL rnd_hist_shift_%0d: got %b want %b", n, hist_shift, d & {L{e}});
      end
      step(d, e, c);
      compared++;
      if (eng_start !== m_start || eng_sel !== 2'(m_sel)) begin
        mismatched++;
        $display("FAIL rnd_launch_%0d: got start=%b sel=%0d want start=%b sel=%0d",
                 n, eng_start, eng_sel, m_start, m_sel);
      end
      compared++;
      if (dout_valid !== e_dv) begin
        mismatched++;
        $display("FAIL rnd_dout_%0d: got %b want %b", n, dout_valid, e_dv);
      end
      compared++;
      if (busy !== e_busy) begin
        mismatched++;
        $display("FAIL rnd_busy_%0d: got %b want %b", n, busy, e_busy);
      end
      compared++;
      if (overflow !== m_ovf) begin
        mismatched++;
        $display("FAIL rnd_overflow_%0d: got %b want %b", n, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_latency();
    test_contention();
    test_overflow();
    test_enable();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
